// File: rtl/sva_stim_pkg.sv
// sva_stim_pkg: command kinds and driver states shared by the sequence stimulus driver.
package sva_stim_pkg;

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        FAIL_NO_A = 2'd1,
        PASS_ZERO = 2'd2,
        RSVD      = 2'd3
    } cmd_kind_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FIRE   = 3'd3,
        NOA    = 3'd4
    } drv_state_t;

endpackage

// File: rtl/sva_seq_driver.sv
// sva_seq_driver: drives a/b for the "a ##1 !b[*0:$] ##1 b" checker from queued commands,
// with exp_succ/exp_fail pulses aligned to the cycle the checker must report.
module sva_seq_driver
    import sva_stim_pkg::*;
#(
    parameter int GAP_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 gclk,
    input  logic                 grst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_kind,
    input  logic [GAP_WIDTH-1:0] cmd_gap,
    output logic                 a,
    output logic                 b,
    output logic                 busy,
    output logic                 exp_succ,
    output logic                 exp_fail,
    output logic                 cmd_err,
    output logic [CNT_WIDTH-1:0] txn_count
);

    drv_state_t           state_q, state_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 a_q, b_q, succ_q, fail_q, err_q;
    logic                 a_d, b_d, succ_d, fail_d, err_d;
    logic                 accept;
    cmd_kind_t            kind;

    always_comb begin
        cmd_ready = (state_q == IDLE) | (state_q == FIRE) | (state_q == NOA);
        accept    = cmd_valid & cmd_ready;
        kind      = cmd_kind_t'(cmd_kind);
        state_d   = state_q;
        gap_d     = gap_q;
        err_d     = 1'b0;
        case (state_q)
            LAUNCH:  state_d = (gap_q != '0) ? WAIT : FIRE;
            WAIT: begin
                state_d = (gap_q == GAP_WIDTH'(1)) ? FIRE : WAIT;
                gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A command accepted in FIRE/NOA chains straight into its first cycle.
        if (accept) begin
            state_d = (kind == FAIL_NO_A) ? NOA : (kind == RSVD) ? IDLE : LAUNCH;
            gap_d   = (kind == PASS) ? cmd_gap : '0;
            err_d   = (kind == RSVD);
        end
        cnt_d  = ((state_q == FIRE) | (state_q == NOA)) & ~&cnt_q ? cnt_q + 1'b1 : cnt_q;
        a_d    = (state_d == LAUNCH);
        b_d    = (state_d == FIRE);
        succ_d = (state_d == FIRE);
        fail_d = (state_d == NOA);
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            succ_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            succ_q  <= succ_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign exp_succ  = succ_q;
    assign exp_fail  = fail_q;
    assign cmd_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_sva_seq_driver.sv
// tb_sva_seq_driver: directed vector table, hand sequences and random commands checked
// against a per-cycle expected-output queue model.
module tb_sva_seq_driver;

    localparam int GW   = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          gclk = 1'b0;
    logic          grst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_kind = 2'd0;
    logic [GW-1:0] cmd_gap = '0;
    logic          cmd_ready, a, b, busy, exp_succ, exp_fail, cmd_err;
    logic [CW-1:0] txn_count;

    sva_seq_driver #(.GAP_WIDTH(GW), .CNT_WIDTH(CW)) dut (
        .gclk(gclk), .grst(grst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_gap(cmd_gap), .a(a), .b(b), .busy(busy),
        .exp_succ(exp_succ), .exp_fail(exp_fail), .cmd_err(cmd_err), .txn_count(txn_count)
    );

    always #5 gclk = ~gclk;

    // One entry per future cycle of a command: what the outputs must show that cycle.
    typedef struct packed {logic a, b, f, e, bz;} ent_t;
    ent_t q[$];
    ent_t cur;
    int   mcnt;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic v; logic [1:0] k; logic [3:0] g;
        logic a, b, s, f, e, bz, rdy; int cnt;
    } vec_t;
    vec_t tv[14];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic err;
        if (cur.b || cur.f) mcnt = (mcnt == CMAX) ? mcnt : mcnt + 1;
        err = 1'b0;
        if (cmd_valid && q.size() == 0) begin
            case (cmd_kind)
                2'd0: begin
                    q.push_back(5'b10001);
                    for (int i = 0; i < int'(cmd_gap); i++) q.push_back(5'b00001);
                    q.push_back(5'b01001);
                end
                2'd2: begin
                    q.push_back(5'b10001);
                    q.push_back(5'b01001);
                end
                2'd1: q.push_back(5'b00101);
                default: err = 1'b1;
            endcase
        end
        cur = (q.size() != 0) ? q.pop_front() : '0;
        cur.e = err;
    endtask

    task automatic check_model();
        chk("m_a", a, cur.a);
        chk("m_b", b, cur.b);
        chk("m_succ", exp_succ, cur.b);
        chk("m_fail", exp_fail, cur.f);
        chk("m_err", cmd_err, cur.e);
        chk("m_busy", busy, cur.bz);
        chk("m_ready", cmd_ready, q.size() == 0);
        chk("m_cnt", txn_count, mcnt);
        chk("m_excl", a & b, 1'b0);
    endtask

    task automatic step(input logic v, input logic [1:0] k, input logic [GW-1:0] g);
        cmd_valid = v;
        cmd_kind  = k;
        cmd_gap   = g;
        @(posedge gclk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        grst = 1'b1;
        q.delete();
        cur  = '0;
        mcnt = 0;
        repeat (2) @(posedge gclk);
        #1 grst = 1'b0;
        check_model();
    endtask

    initial begin
        // v k g | a b s f e busy rdy cnt
        tv[0]  = '{1, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tv[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tv[3]  = '{0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0};
        tv[4]  = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tv[6]  = '{1, 2, 9, 1, 0, 0, 0, 0, 1, 0, 1};
        tv[7]  = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1};
        tv[8]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2};
        tv[9]  = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 2};
        tv[10] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 3};
        tv[11] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 4};
        tv[12] = '{1, 3, 0, 0, 0, 0, 0, 1, 0, 1, 5};
        tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(tv[i].v, tv[i].k, tv[i].g);
            chk($sformatf("tv%0d_a", i), a, tv[i].a);
            chk($sformatf("tv%0d_b", i), b, tv[i].b);
            chk($sformatf("tv%0d_succ", i), exp_succ, tv[i].s);
            chk($sformatf("tv%0d_fail", i), exp_fail, tv[i].f);
            chk($sformatf("tv%0d_err", i), cmd_err, tv[i].e);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bz);
            chk($sformatf("tv%0d_ready", i), cmd_ready, tv[i].rdy);
            chk($sformatf("tv%0d_cnt", i), txn_count, tv[i].cnt);
        end

        // Max gap with cmd_* churning while busy: b lands exactly 17 cycles after accept.
        do_reset();
        step(1'b1, 2'd0, 4'd15);
        for (int i = 2; i <= 17; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            chk($sformatf("gap15_b%0d", i), b, i == 17);
        end
        step(1'b0, 2'd0, 4'd0);

        // Async reset mid-WAIT clears outputs before any clock edge.
        do_reset();
        step(1'b1, 2'd0, 4'd5);
        step(1'b0, 2'd0, 4'd0);
        step(1'b0, 2'd0, 4'd0);
        #2 grst = 1'b1;
        #1;
        chk("rst_a", a, 1'b0);
        chk("rst_b", b, 1'b0);
        chk("rst_succ", exp_succ, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_cnt", txn_count, 0);
        q.delete();
        cur  = '0;
        mcnt = 0;
        @(posedge gclk);
        #1 grst = 1'b0;
        repeat (8) step(1'b0, 2'd0, 4'd0);

        // Counter saturation.
        do_reset();
        repeat (CMAX + 40) step(1'b1, 2'd1, 4'd0);
        step(1'b0, 2'd0, 4'd0);
        chk("sat_cnt", txn_count, CMAX);

        // Random commands against the model.
        do_reset();
        repeat (3000) step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
